// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet front-end driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maxnet_pkg;

  localparam int FP_W  = 32;
  localparam int N_ACT = 4;
  localparam int IDX_W = 3;

  // Index of the last operand slot (a4); slot 0 is epsilon.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ACT);

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // True when the write index points at the final operand of a load.
  function automatic logic idx_is_last(input logic [IDX_W-1:0] idx);
    return idx == IDX_LAST;
  endfunction

endpackage

// File: rtl/maxnet_operand_bank.sv
// Five float operand registers (eps, a1..a4) written by slot index.
// Latency: a write appears on the outputs the cycle after wr_en_i.
// Backpressure: none; the caller gates wr_en_i with its own handshake.
module maxnet_operand_bank
  import maxnet_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [FP_W-1:0]  wr_data_i,
  output logic [FP_W-1:0]  eps_o,
  output logic [FP_W-1:0]  a1_o,
  output logic [FP_W-1:0]  a2_o,
  output logic [FP_W-1:0]  a3_o,
  output logic [FP_W-1:0]  a4_o
);

  logic [FP_W-1:0] op_q [N_ACT+1];

  // Decoded per-slot write; words are stored bit-exact, never interpreted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N_ACT; i++) begin
        op_q[i] <= FP_ZERO;
      end
    end else begin
      for (int i = 0; i <= N_ACT; i++) begin
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          op_q[i] <= wr_data_i;
        end
      end
    end
  end

  assign eps_o = op_q[0];
  assign a1_o  = op_q[1];
  assign a2_o  = op_q[2];
  assign a3_o  = op_q[3];
  assign a4_o  = op_q[4];

endmodule

// File: rtl/maxnet_driver.sv
// Loads eps+a1..a4 from a stream, pulses start to Maxnet, returns its result (or a timeout error).
// Latency: start 1 cycle after the 5th word; result 1 cycle after finish or TIMEOUT+1 cycles after start.
// Backpressure: in_ready only in LOAD; result held on res_valid until res_ready, no input/result overlap.
module maxnet_driver
  import maxnet_pkg::*;
#(
  parameter int TIMEOUT = 1024,  // must be >= 2
  parameter int CNT_W   = 16     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_data,
  output logic            mx_start,
  output logic [FP_W-1:0] mx_eps,
  output logic [FP_W-1:0] mx_a1,
  output logic [FP_W-1:0] mx_a2,
  output logic [FP_W-1:0] mx_a3,
  output logic [FP_W-1:0] mx_a4,
  input  logic            mx_finish,
  input  logic [FP_W-1:0] mx_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FP_W-1:0] res_data,
  output logic            res_err,
  output logic            busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0]  res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic             in_xfer;

  // Operand writes only happen on accepted LOAD words, so the bank is frozen from START to RESULT.
  assign in_xfer = (state_q == ST_LOAD) && in_valid;

  maxnet_operand_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_xfer),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_data),
    .eps_o     (mx_eps),
    .a1_o      (mx_a1),
    .a2_o      (mx_a2),
    .a3_o      (mx_a3),
    .a4_o      (mx_a4)
  );

  // State, load index, wait counter and captured result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= FP_ZERO;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // Next-state logic; finish is only looked at in WAIT, so a stale finish elsewhere is harmless.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_LOAD: begin
        if (in_xfer) begin
          if (idx_is_last(idx_q)) begin
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Finish takes priority when it lands on the last allowed cycle.
        if (mx_finish) begin
          res_data_d = mx_out;
          res_err_d  = 1'b0;
          state_d    = ST_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          res_data_d = FP_ZERO;
          res_err_d  = 1'b1;
          state_d    = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign mx_start  = (state_q == ST_START);
  assign busy      = (state_q == ST_START) || (state_q == ST_WAIT);
  assign res_valid = (state_q == ST_RESULT);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_maxnet_driver.sv
// Bench for maxnet_driver: dut0 uses a long timeout, dut1 uses TIMEOUT=16.
// Results are scoreboarded; handshake timing and operands are checked inline.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_maxnet_driver;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        mx_start  [2];
  logic [31:0] mx_eps    [2];
  logic [31:0] mx_a1     [2];
  logic [31:0] mx_a2     [2];
  logic [31:0] mx_a3     [2];
  logic [31:0] mx_a4     [2];
  logic        mx_finish [2];
  logic [31:0] mx_out    [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_data  [2];
  logic        res_err   [2];
  logic        busy      [2];

  int n_cmp;
  int n_err;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [31:0] w[5];

  maxnet_driver #(.TIMEOUT(64), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .mx_start(mx_start[0]), .mx_eps(mx_eps[0]), .mx_a1(mx_a1[0]), .mx_a2(mx_a2[0]),
    .mx_a3(mx_a3[0]), .mx_a4(mx_a4[0]), .mx_finish(mx_finish[0]), .mx_out(mx_out[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_err(res_err[0]), .busy(busy[0])
  );

  maxnet_driver #(.TIMEOUT(16), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .mx_start(mx_start[1]), .mx_eps(mx_eps[1]), .mx_a1(mx_a1[1]), .mx_a2(mx_a2[1]),
    .mx_a3(mx_a3[1]), .mx_a4(mx_a4[1]), .mx_finish(mx_finish[1]), .mx_out(mx_out[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_err(res_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: actual %h required %h", name, d, act, exp);
    end
  endtask

  task automatic chk_b(input int d, input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: actual %b required %b", name, d, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input logic err, input logic [31:0] data);
    if (d == 0) exp_q0.push_back({err, data});
    else        exp_q1.push_back({err, data});
  endtask

  task automatic chk_reset(input int d);
    chk_b(d, "rst_in_ready",  in_ready[d],  1'b1);
    chk_b(d, "rst_mx_start",  mx_start[d],  1'b0);
    chk_b(d, "rst_res_valid", res_valid[d], 1'b0);
    chk_b(d, "rst_res_err",   res_err[d],   1'b0);
    chk_b(d, "rst_busy",      busy[d],      1'b0);
    chk(d, "rst_res_data", res_data[d], 32'h0);
    chk(d, "rst_eps", mx_eps[d], 32'h0);
    chk(d, "rst_a1",  mx_a1[d],  32'h0);
    chk(d, "rst_a2",  mx_a2[d],  32'h0);
    chk(d, "rst_a3",  mx_a3[d],  32'h0);
    chk(d, "rst_a4",  mx_a4[d],  32'h0);
  endtask

  task automatic chk_ops(input int d, input string tag);
    chk(d, {tag, "_eps"}, mx_eps[d], w[0]);
    chk(d, {tag, "_a1"},  mx_a1[d],  w[1]);
    chk(d, {tag, "_a2"},  mx_a2[d],  w[2]);
    chk(d, {tag, "_a3"},  mx_a3[d],  w[3]);
    chk(d, {tag, "_a4"},  mx_a4[d],  w[4]);
  endtask

  // Five-word load; returns positioned in the START cycle.
  task automatic load(input int d, input bit stall);
    int n;
    for (int k = 0; k < 5; k++) begin
      if (stall) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          in_valid[d] = 1'b0;
          in_data[d]  = $urandom;
          step();
          chk_b(d, "stall_in_ready", in_ready[d], 1'b1);
          chk_b(d, "stall_no_start", mx_start[d], 1'b0);
        end
      end
      in_valid[d] = 1'b1;
      in_data[d]  = w[k];
      step();
      if (k < 4) begin
        chk_b(d, "load_in_ready", in_ready[d], 1'b1);
        chk_b(d, "early_start",   mx_start[d], 1'b0);
      end
    end
    in_valid[d] = 1'b0;
    chk_b(d, "start_pulse",    mx_start[d], 1'b1);
    chk_b(d, "start_in_ready", in_ready[d], 1'b0);
    chk_b(d, "start_busy",     busy[d],     1'b1);
  endtask

  // Result monitor: pops the scoreboard on every accepted result.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (res_valid[d] && res_ready[d]) begin
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result dut%0d: actual data %h err %b required no result",
                     d, res_data[d], res_err[d]);
          end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk(d, "res_data", res_data[d], e[31:0]);
            chk_b(d, "res_err", res_err[d], e[32]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] held;
    n_cmp = 0;
    n_err = 0;
    w[0] = 32'hBE4C_CCCD;
    w[1] = 32'h42FD_6666;
    w[2] = 32'hC0A0_0000;
    w[3] = 32'h0000_0000;
    w[4] = 32'hBE4C_CCCD;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 32'h0;
      mx_finish[d] = 1'b0;
      mx_out[d]    = 32'h0;
      res_ready[d] = 1'b1;
    end
    repeat (3) step();
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    step();

    // Clean load, finish after 40 cycles.
    load(0, 1'b0);
    chk_ops(0, "t1_op");
    step();
    chk_b(0, "t1_start_one_cycle", mx_start[0], 1'b0);
    chk_b(0, "t1_wait_busy", busy[0], 1'b1);
    repeat (39) step();
    chk_b(0, "t1_no_early_result", res_valid[0], 1'b0);
    mx_finish[0] = 1'b1;
    mx_out[0]    = 32'h42FD_6666;
    push_exp(0, 1'b0, 32'h42FD_6666);
    step();
    mx_finish[0] = 1'b0;
    chk_b(0, "t1_res_valid", res_valid[0], 1'b1);
    chk_b(0, "t1_res_busy", busy[0], 1'b0);
    step();
    chk_b(0, "t1_back_ready", in_ready[0], 1'b1);
    chk_b(0, "t1_res_dropped", res_valid[0], 1'b0);

    // Stalled load, input pressure during WAIT, held result, stale finish.
    load(0, 1'b1);
    chk_ops(0, "t2_op");
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hDEAD_BEEF;
    repeat (10) begin
      step();
      chk_b(0, "t2_wait_in_ready", in_ready[0], 1'b0);
      chk_ops(0, "t2_wait_op");
    end
    in_valid[0]  = 1'b0;
    res_ready[0] = 1'b0;
    mx_finish[0] = 1'b1;
    mx_out[0]    = 32'h0000_0001;
    push_exp(0, 1'b0, 32'h0000_0001);
    step();
    chk_b(0, "t2_res_valid", res_valid[0], 1'b1);
    held = res_data[0];
    chk(0, "t2_res_data_capture", held, 32'h0000_0001);
    mx_out[0] = 32'h1234_5678;
    repeat (10) begin
      step();
      chk_b(0, "t2_hold_valid", res_valid[0], 1'b1);
      chk(0, "t2_hold_data", res_data[0], 32'h0000_0001);
      chk_b(0, "t2_hold_err", res_err[0], 1'b0);
      chk_b(0, "t2_hold_in_ready", in_ready[0], 1'b0);
    end
    res_ready[0] = 1'b1;
    step();
    chk_b(0, "t2_accept_in_ready", in_ready[0], 1'b1);
    chk_b(0, "t2_accept_valid", res_valid[0], 1'b0);
    repeat (8) begin
      step();
      chk_b(0, "t2_stale_no_result", res_valid[0], 1'b0);
      chk_b(0, "t2_stale_no_start", mx_start[0], 1'b0);
      chk_b(0, "t2_stale_idle", busy[0], 1'b0);
    end
    mx_finish[0] = 1'b0;

    // Reset at WAIT count 5, then a normal run.
    load(0, 1'b0);
    step();
    repeat (5) step();
    chk_b(0, "t3_in_wait", busy[0], 1'b1);
    rst = 1'b1;
    step();
    chk_reset(0);
    rst = 1'b0;
    step();
    chk_b(0, "t3_no_result_after_rst", res_valid[0], 1'b0);
    load(0, 1'b0);
    chk_ops(0, "t3_op");
    step();
    repeat (2) step();
    mx_finish[0] = 1'b1;
    mx_out[0]    = 32'hC0A0_0000;
    push_exp(0, 1'b0, 32'hC0A0_0000);
    step();
    mx_finish[0] = 1'b0;
    chk_b(0, "t3_res_valid", res_valid[0], 1'b1);
    step();

    // Reset in LOAD at idx 3, then a full load must still need five words.
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = w[k];
      step();
    end
    in_data[0] = w[3];
    rst = 1'b1;
    step();
    chk_reset(0);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    step();
    load(0, 1'b0);
    chk_ops(0, "t4_op");
    step();
    mx_finish[0] = 1'b1;
    mx_out[0]    = 32'h42FD_6666;
    push_exp(0, 1'b0, 32'h42FD_6666);
    step();
    mx_finish[0] = 1'b0;
    chk_b(0, "t4_res_valid", res_valid[0], 1'b1);
    step();

    // TIMEOUT=16, no finish: result 17 cycles after start.
    load(1, 1'b0);
    chk_ops(1, "t5_op");
    push_exp(1, 1'b1, 32'h0);
    repeat (16) step();
    chk_b(1, "t5_not_yet", res_valid[1], 1'b0);
    step();
    chk_b(1, "t5_timeout_valid", res_valid[1], 1'b1);
    step();
    chk_b(1, "t5_back_ready", in_ready[1], 1'b1);

    // Finish on the very cycle the timeout would fire: finish wins.
    load(1, 1'b0);
    repeat (16) step();
    mx_finish[1] = 1'b1;
    mx_out[1]    = 32'hC0A0_0000;
    push_exp(1, 1'b0, 32'hC0A0_0000);
    step();
    mx_finish[1] = 1'b0;
    chk_b(1, "t6_res_valid", res_valid[1], 1'b1);
    step();

    repeat (3) step();
    chk(0, "scoreboard_drained", exp_q0.size(), 32'd0);
    chk(1, "scoreboard_drained", exp_q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
